instruction_encoder: RTL and testbench



---
 rtl/instruction_encoder.sv | 100 ++++++++++
 tb/tb_instruction_encoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Packs decoded instruction fields into 32-bit words and streams them out through a small FIFO.
// Optional even-parity bit 26 is generated when INSTR_ENC_PARITY_EN is defined.
module instruction_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_alu_src,
  input  logic [3:0]       in_reg1,
  input  logic [3:0]       in_reg2,
  input  logic [3:0]       in_reg_dest,
  input  logic [11:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             illegal,
  output logic [CNT_W-1:0] count,
  output logic [AW:0]      fifo_level
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LAST = 3'd4;

  logic [31:0]      mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_q, illegal_d;
  logic [31:0]      word_d;
  logic             full, empty, accept, push, pop, legal;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign legal = (in_op <= OP_LAST);

  assign in_ready = !full && !rst;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign pop      = !empty && out_ready;

  always_comb begin
    word_d = 32'h0;
    if (in_op != OP_NOP) begin
      word_d[31:28] = {1'b0, in_op};
      word_d[27]    = in_alu_src;
      word_d[23:20] = in_reg_dest;
      word_d[19:16] = in_reg1;
      // Immediate form drops reg2; register form drops the immediate.
      word_d[15:12] = in_alu_src ? 4'h0 : in_reg2;
      word_d[11:0]  = in_alu_src ? in_imm : 12'h000;
`ifdef INSTR_ENC_PARITY_EN
      // Bit 26 is still zero here, so the reduction covers only the other bits.
      word_d[26]    = ^word_d;
`endif
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    illegal_d = accept && !legal;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Storage needs no reset: empty pointers mask stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= word_d;
  end

  assign out_valid  = !empty;
  assign out_instr  = empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];
  assign illegal    = illegal_q;
  assign count      = count_q;
  assign fifo_level = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: encoding, masking, illegal drop, full/drain, streaming and reset.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_alu_src;
  logic [3:0]  in_reg1, in_reg2, in_reg_dest;
  logic [11:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        illegal;
  logic [15:0] count;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  instruction_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_alu_src(in_alu_src),
    .in_reg1(in_reg1), .in_reg2(in_reg2), .in_reg_dest(in_reg_dest), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .illegal(illegal), .count(count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_tuple(input logic [2:0] op, input logic src, input logic [3:0] dest,
                           input logic [3:0] r1, input logic [3:0] r2, input logic [11:0] imm);
    in_op = op; in_alu_src = src; in_reg_dest = dest; in_reg1 = r1; in_reg2 = r2; in_imm = imm;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_tuple(3'd0, 1'b0, 4'h0, 4'h0, 4'h0, 12'h000);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h exp 00000000", out_instr); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
  endtask

  // Each vector is pushed alone, checked one cycle later, then drained.
  task automatic test_encoding;
    logic [31:0] exp;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin set_tuple(3'd1, 1'b0, 4'h3, 4'h0, 4'h1, 12'hFFF); exp = 32'h1030_1000; end
        1: begin set_tuple(3'd2, 1'b1, 4'h4, 4'h1, 4'h7, 12'h005); exp = 32'h2841_0005; end
`ifdef INSTR_ENC_PARITY_EN
        2: begin set_tuple(3'd3, 1'b0, 4'h1, 4'h0, 4'h0, 12'hABC); exp = 32'h3410_0000; end
        3: begin set_tuple(3'd4, 1'b1, 4'h2, 4'h5, 4'h9, 12'h123); exp = 32'h4C25_0123; end
`else
        2: begin set_tuple(3'd3, 1'b0, 4'h1, 4'h0, 4'h0, 12'hABC); exp = 32'h3010_0000; end
        3: begin set_tuple(3'd4, 1'b1, 4'h2, 4'h5, 4'h9, 12'h123); exp = 32'h4825_0123; end
`endif
        default: begin set_tuple(3'd0, 1'b1, 4'hF, 4'hF, 4'hF, 12'hFFF); exp = 32'h0000_0000; end
      endcase
      in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL enc%0d_valid got %b exp 1", i, out_valid); end
      checks++; if (out_instr !== exp) begin errors++; $display("FAIL enc%0d_instr got %h exp %h", i, out_instr, exp); end
      checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL enc%0d_level got %0d exp 1", i, fifo_level); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (count !== 16'(i + 1)) begin errors++; $display("FAIL enc%0d_count got %0d exp %0d", i, count, i + 1); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL enc%0d_drained got %b exp 0", i, out_valid); end
    end
  endtask

  task automatic test_illegal;
    set_tuple(3'd6, 1'b0, 4'h1, 4'h2, 4'h3, 12'h456);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse got %b exp 1", illegal); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL illegal_level got %0d exp 0", fifo_level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_out_valid got %b exp 0", out_valid); end
    tick();
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_width got %b exp 0", illegal); end
  endtask

  task automatic test_full_drain;
    logic [31:0] w [5];
    w[0] = 32'h1010_0000; w[1] = 32'h2020_0000; w[2] = 32'h4000_1000;
    w[3] = 32'h3000_0000; w[4] = 32'h1800_000F;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_tuple(3'd1, 1'b0, 4'h1, 4'h0, 4'h0, 12'h000);
        1: set_tuple(3'd2, 1'b0, 4'h2, 4'h0, 4'h0, 12'h000);
        2: set_tuple(3'd4, 1'b0, 4'h0, 4'h0, 4'h1, 12'h000);
        default: set_tuple(3'd3, 1'b0, 4'h0, 4'h0, 4'h0, 12'hFFF);
      endcase
      tick();
    end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level got %0d exp 4", fifo_level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    checks++; if (out_instr !== w[0]) begin errors++; $display("FAIL full_head got %h exp %h", out_instr, w[0]); end
    set_tuple(3'd1, 1'b1, 4'h0, 4'h0, 4'hF, 12'h00F);
    tick();
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_hold_level got %0d exp 4", fifo_level); end
    checks++; if (out_instr !== w[0]) begin errors++; $display("FAIL full_hold_head got %h exp %h", out_instr, w[0]); end
    out_ready = 1'b1;
    tick();
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL pop1_level got %0d exp 3", fifo_level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pop1_in_ready got %b exp 1", in_ready); end
    checks++; if (out_instr !== w[1]) begin errors++; $display("FAIL pop1_head got %h exp %h", out_instr, w[1]); end
    tick();
    in_valid = 1'b0;
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL pushpop_level got %0d exp 3", fifo_level); end
    for (int i = 2; i < 5; i++) begin
      checks++; if (out_instr !== w[i]) begin errors++; $display("FAIL drain%0d got %h exp %h", i, out_instr, w[i]); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL drain_instr got %h exp 00000000", out_instr); end
    checks++; if (count !== 16'd10) begin errors++; $display("FAIL drain_count got %0d exp 10", count); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w [3];
    w[0] = 32'h1010_0000; w[1] = 32'h2020_0000; w[2] = 32'h4000_1000;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_tuple(3'd1, 1'b0, 4'h1, 4'h0, 4'h0, 12'h000);
        1: set_tuple(3'd2, 1'b0, 4'h2, 4'h0, 4'h0, 12'h000);
        default: set_tuple(3'd4, 1'b0, 4'h0, 4'h0, 4'h1, 12'h000);
      endcase
      tick();
      checks++; if (out_instr !== w[i]) begin errors++; $display("FAIL b2b%0d_instr got %h exp %h", i, out_instr, w[i]); end
      checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL b2b%0d_level got %0d exp 1", i, fifo_level); end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 16'd13) begin errors++; $display("FAIL b2b_count got %0d exp 13", count); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL b2b_level_end got %0d exp 0", fifo_level); end
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b0; in_valid = 1'b1;
    set_tuple(3'd1, 1'b0, 4'h1, 4'h0, 4'h0, 12'h000); tick();
    set_tuple(3'd2, 1'b0, 4'h2, 4'h0, 4'h0, 12'h000); tick();
    set_tuple(3'd4, 1'b0, 4'h0, 4'h0, 4'h1, 12'h000); tick();
    set_tuple(3'd7, 1'b0, 4'h0, 4'h0, 4'h0, 12'h000); tick();
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_level got %0d exp 3", fifo_level); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL mid_illegal got %b exp 1", illegal); end
    set_tuple(3'd1, 1'b0, 4'h1, 4'h0, 4'h0, 12'h000);
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got %b exp 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_rst_level got %0d exp 0", fifo_level); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", count); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL mid_instr got %h exp 00000000", out_instr); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL mid_illegal_cancel got %b exp 0", illegal); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_encoding();
    test_illegal();
    test_full_drain();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
